// File: rtl/plot_sink_pkg.sv
// Shared constants, state encoding and pixel payload for the plot sink.
// Contents:
//   screen geometry (WIDTH, HEIGHT, TILE, grid limits), FIFO depth,
//   transparent key colour, coordinate widths, state_t, pixel_t.
package plot_sink_pkg;

    localparam int unsigned WIDTH     = 320;
    localparam int unsigned HEIGHT    = 240;
    localparam int unsigned TILE      = 16;
    localparam int unsigned GRID_COLS = 20;
    localparam int unsigned GRID_ROWS = 15;
    localparam int unsigned DEPTH     = 4;

    localparam int unsigned X_W      = 9;
    localparam int unsigned Y_W      = 8;
    localparam int unsigned COLOUR_W = 3;
    localparam int unsigned OFFSET_W = 17;
    localparam int unsigned COUNT_W  = 17;
    localparam int unsigned COORD_W  = 10;
    localparam int unsigned COL_W    = 5;
    localparam int unsigned ROW_W    = 4;

    localparam logic [COLOUR_W-1:0] KEY_COLOUR = 3'b101;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [X_W-1:0]      x;
        logic [Y_W-1:0]      y;
        logic [COLOUR_W-1:0] colour;
    } pixel_t;

    // True when a 10-bit coordinate pair lies on the visible screen.
    function automatic logic on_screen(input logic [COORD_W-1:0] x,
                                       input logic [COORD_W-1:0] y);
        return (x < COORD_W'(WIDTH)) && (y < COORD_W'(HEIGHT));
    endfunction

endpackage

// File: rtl/plot_sink_if.sv
// Plot port between the sink and the VGA adapter.
// Signals: plot (valid), plot_x, plot_y, plot_colour, plot_ready.
// Modports: master = pixel producer (plot_sink), slave = VGA adapter side.
interface plot_sink_if;
    import plot_sink_pkg::*;

    logic                plot;
    logic [X_W-1:0]      plot_x;
    logic [Y_W-1:0]      plot_y;
    logic [COLOUR_W-1:0] plot_colour;
    logic                plot_ready;

    modport master (output plot, plot_x, plot_y, plot_colour, input plot_ready);
    modport slave  (input plot, plot_x, plot_y, plot_colour, output plot_ready);
endinterface

// File: rtl/plot_sink_pixel_fifo.sv
// First-word-fall-through FIFO for plot pixels.
// Ports: clk, rst (async active-high), push/wdata, pop/rdata (head entry),
//        full, empty, count (occupancy 0..DEPTH).
// Callers must not push when full without a same-cycle pop, nor pop when empty.
module plot_sink_pixel_fifo #(
    parameter int unsigned W     = 20,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [W-1:0]               wdata,
    input  logic                       pop,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
endmodule

// File: rtl/plot_sink.sv
// Receiving end of the pixel-copy write stream.
// Translates each pixel offset (screen or tile-relative) to (x, y), buffers it
// in a FWFT FIFO and presents it on the plot port with ready/valid handshake.
// Ports: clk, reset_n (async, HIGH = reset), wr_en/colour/offset/tile_mode/
//        tile_col/tile_row (write side), src_finished, plot_bus (plot port),
//        busy, done (1-cycle), overflow/clipped (sticky), pixel_count.
// Build option: define TRANSPARENCY_EN to discard pixels of KEY_COLOUR.
module plot_sink
    import plot_sink_pkg::*;
(
    input  logic                clk,
    input  logic                reset_n,
    input  logic                wr_en,
    input  logic [COLOUR_W-1:0] colour,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                tile_mode,
    input  logic [COL_W-1:0]    tile_col,
    input  logic [ROW_W-1:0]    tile_row,
    input  logic                src_finished,
    plot_sink_if.master         plot_bus,
    output logic                busy,
    output logic                done,
    output logic                overflow,
    output logic                clipped,
    output logic [COUNT_W-1:0]  pixel_count
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    state_t           state;
    logic [COORD_W-1:0] x_c;
    logic [COORD_W-1:0] y_c;
    logic             key_c;
    logic             keep_c;
    logic             want_c;
    logic             push;
    logic             pop;
    logic             set_clip;
    logic             set_ovf;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] fifo_count;
    pixel_t           wr_pix;
    pixel_t           head;

    // Offset to screen coordinates, 10-bit intermediate sums.
    always_comb begin
        x_c = COORD_W'(offset[X_W-1:0]);
        y_c = COORD_W'(offset[OFFSET_W-1:X_W]);
        if (tile_mode) begin
            x_c = COORD_W'(tile_col) * COORD_W'(TILE) + COORD_W'(offset[3:0]);
            y_c = COORD_W'(tile_row) * COORD_W'(TILE) + COORD_W'(offset[7:4]);
        end
    end

`ifdef TRANSPARENCY_EN
    assign key_c = (colour == KEY_COLOUR);
`else
    assign key_c = 1'b0;
`endif

    assign keep_c   = wr_en & ~key_c;
    assign want_c   = keep_c & on_screen(x_c, y_c);
    assign pop      = ~empty & plot_bus.plot_ready;
    assign push     = want_c & (~full | pop);
    assign set_clip = keep_c & ~on_screen(x_c, y_c);
    assign set_ovf  = want_c & (fifo_count == CNT_W'(DEPTH)) & ~pop;
    assign wr_pix   = '{x: x_c[X_W-1:0], y: y_c[Y_W-1:0], colour: colour};

    plot_sink_pixel_fifo #(
        .W     ($bits(pixel_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (reset_n),
        .push  (push),
        .wdata (wr_pix),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (fifo_count)
    );

    assign plot_bus.plot        = ~empty;
    assign plot_bus.plot_x      = head.x;
    assign plot_bus.plot_y      = head.y;
    assign plot_bus.plot_colour = head.colour;

    // Per-transfer statistics; a new transfer restarts them but still records
    // what its own first pixel does.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            overflow    <= 1'b0;
            clipped     <= 1'b0;
            pixel_count <= '0;
        end else if (state == IDLE && wr_en) begin
            overflow    <= set_ovf;
            clipped     <= set_clip;
            pixel_count <= '0;
        end else begin
            if (set_ovf)  overflow <= 1'b1;
            if (set_clip) clipped  <= 1'b1;
            if (pop && pixel_count != '1) pixel_count <= pixel_count + COUNT_W'(1);
        end
    end

    // Transfer sequencing with registered busy/done.
    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        state <= ACTIVE;
                        busy  <= 1'b1;
                    end else if (src_finished) begin
                        state <= DRAIN;
                        busy  <= 1'b1;
                    end
                end
                ACTIVE: begin
                    if (src_finished) state <= DRAIN;
                end
                DRAIN: begin
                    // Empty with nothing arriving means the last pixel has left.
                    if (empty && !push) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    // A pixel arriving here opens a new transfer without
                    // restarting the statistics.
                    if (wr_en) begin
                        state <= ACTIVE;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_plot_sink.sv
// Randomised self-checking bench for plot_sink with a queue-based reference model.
module tb_plot_sink;
    import plot_sink_pkg::*;

    typedef struct { int x; int y; int c; } px_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        wr_en = 1'b0;
    logic [2:0]  colour = '0;
    logic [16:0] offset = '0;
    logic        tile_mode = 1'b0;
    logic [4:0]  tile_col = '0;
    logic [3:0]  tile_row = '0;
    logic        src_finished = 1'b0;
    logic        busy, done, overflow, clipped;
    logic [16:0] pixel_count;

    plot_sink_if bus();

    plot_sink dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .wr_en        (wr_en),
        .colour       (colour),
        .offset       (offset),
        .tile_mode    (tile_mode),
        .tile_col     (tile_col),
        .tile_row     (tile_row),
        .src_finished (src_finished),
        .plot_bus     (bus),
        .busy         (busy),
        .done         (done),
        .overflow     (overflow),
        .clipped      (clipped),
        .pixel_count  (pixel_count)
    );

    always #5 clk = ~clk;

    px_t mq[$];      // model FIFO contents
    px_t exp_q[$];   // pixels the model says get plotted
    px_t got_q[$];   // pixels observed leaving the plot port
    int  m_state;    // 0 idle, 1 active, 2 drain, 3 done
    int  m_count;
    bit  m_ovf, m_clip;
    int  done_cnt;
    int  tests, fails;

    task automatic model_reset();
        mq.delete();
        m_state = 0;
        m_count = 0;
        m_ovf   = 0;
        m_clip  = 0;
    endtask

    // One clock cycle: record handshake, advance the model, step to next negedge.
    task automatic tick();
        px_t g, p;
        int  sz;
        bit  pop, pushed, key;
        sz = mq.size();
        pop = (sz > 0) && (bus.plot_ready === 1'b1);
        if (bus.plot === 1'b1 && bus.plot_ready === 1'b1) begin
            g.x = int'(bus.plot_x);
            g.y = int'(bus.plot_y);
            g.c = int'(bus.plot_colour);
            got_q.push_back(g);
        end
        if (pop) begin
            exp_q.push_back(mq.pop_front());
            if (m_count < 131071) m_count++;
        end
        pushed = 0;
        if (m_state == 0 && wr_en) begin
            m_count = 0;
            m_ovf   = 0;
            m_clip  = 0;
        end
        if (wr_en) begin
            if (tile_mode) begin
                p.x = int'(tile_col) * 16 + int'(offset[3:0]);
                p.y = int'(tile_row) * 16 + int'(offset[7:4]);
            end else begin
                p.x = int'(offset[8:0]);
                p.y = int'(offset[16:9]);
            end
            p.c = int'(colour);
            key = 0;
`ifdef TRANSPARENCY_EN
            key = (colour == 3'b101);
`endif
            if (!key) begin
                if (p.x >= 320 || p.y >= 240) m_clip = 1;
                else if (sz < 4 || pop) begin
                    mq.push_back(p);
                    pushed = 1;
                end else m_ovf = 1;
            end
        end
        case (m_state)
            0: if (wr_en) m_state = 1; else if (src_finished) m_state = 2;
            1: if (src_finished) m_state = 2;
            2: if (sz == 0 && !pushed) m_state = 3;
            default: m_state = wr_en ? 1 : 0;
        endcase
        @(posedge clk);
        @(negedge clk);
        if (done === 1'b1) done_cnt++;
    endtask

    task automatic finish_and_drain(output bit timed_out);
        int start;
        start = done_cnt;
        src_finished = 1'b1;
        tick();
        src_finished = 1'b0;
        timed_out = 1;
        for (int i = 0; i < 300; i++) begin
            if (done_cnt != start) begin
                timed_out = 0;
                break;
            end
            tick();
        end
        tick();
    endtask

    function automatic int diff_pixels();
        int bad = 0;
        if (got_q.size() != exp_q.size()) bad++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i].x != exp_q[i].x || got_q[i].y != exp_q[i].y || got_q[i].c != exp_q[i].c) bad++;
        return bad;
    endfunction

    task automatic start_test();
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        bus.plot_ready = 1'b0;
        reset_n = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        tests++;
        if ({bus.plot, busy, done, overflow, clipped} !== 5'b0 || pixel_count !== 17'd0) begin
            fails++;
            $display("FAIL reset_hold: plot=%b busy=%b done=%b ovf=%b clip=%b cnt=%0d, want all 0",
                     bus.plot, busy, done, overflow, clipped, pixel_count);
        end
        reset_n = 1'b0;
        tick();
        tests++;
        if (bus.plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_release: plot=%b busy=%b done=%b, want 0", bus.plot, busy, done);
        end
    endtask

    task automatic test_single();
        bit to;
        int d0;
        start_test();
        d0 = done_cnt;
        bus.plot_ready = 1'b1;
        tile_mode = 1'b0;
        offset = {8'd10, 9'd37};
        colour = 3'b010;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tests++;
        if (bus.plot !== 1'b1 || bus.plot_x !== 9'd37 || bus.plot_y !== 8'd10 || bus.plot_colour !== 3'd2) begin
            fails++;
            $display("FAIL single_latency: plot=%b x=%0d y=%0d c=%0d, want 1 37 10 2",
                     bus.plot, bus.plot_x, bus.plot_y, bus.plot_colour);
        end
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL single_busy: busy=%b, want 1", busy);
        end
        finish_and_drain(to);
        tests++;
        if (to !== 1'b0 || done_cnt - d0 !== 1) begin
            fails++;
            $display("FAIL single_done: timeout=%b pulses=%0d, want 0 and 1", to, done_cnt - d0);
        end
        tests++;
        if (pixel_count !== 17'd1 || busy !== 1'b0 || diff_pixels() !== 0) begin
            fails++;
            $display("FAIL single_end: cnt=%0d busy=%b diffs=%0d, want 1 0 0", pixel_count, busy, diff_pixels());
        end
    endtask

    task automatic test_tile();
        bit to;
        int d0;
        start_test();
        d0 = done_cnt;
        bus.plot_ready = 1'b1;
        tile_mode = 1'b1;
        tile_col = 5'd19;
        tile_row = 4'd14;
        for (int i = 0; i < 256; i++) begin
            offset = 17'(i);
            colour = 3'($urandom_range(0, 3));
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        finish_and_drain(to);
        tests++;
        if (diff_pixels() !== 0 || got_q.size() !== 256) begin
            fails++;
            $display("FAIL tile_stream: diffs=%0d got=%0d pixels, want 0 and 256", diff_pixels(), got_q.size());
        end
        tests++;
        if (got_q.size() < 256 || got_q[0].x !== 304 || got_q[0].y !== 224 || got_q[255].x !== 319 || got_q[255].y !== 239) begin
            fails++;
            $display("FAIL tile_corners: got %0d pixels, first/last corner mismatch, want (304,224)..(319,239)", got_q.size());
        end
        tests++;
        if (pixel_count !== 17'd256 || clipped !== 1'b0 || overflow !== 1'b0 || done_cnt - d0 !== 1 || to !== 1'b0) begin
            fails++;
            $display("FAIL tile_flags: cnt=%0d clip=%b ovf=%b pulses=%0d, want 256 0 0 1",
                     pixel_count, clipped, overflow, done_cnt - d0);
        end
        tile_mode = 1'b0;
    endtask

    task automatic test_backpressure();
        bit to;
        logic [19:0] snap;
        start_test();
        bus.plot_ready = 1'b0;
        tile_mode = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offset = {8'($urandom_range(0, 239)), 9'($urandom_range(0, 319))};
            colour = 3'($urandom_range(0, 3));
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        tests++;
        if (overflow !== 1'b1 || bus.plot !== 1'b1) begin
            fails++;
            $display("FAIL bp_overflow: ovf=%b plot=%b, want 1 1", overflow, bus.plot);
        end
        tests++;
        if (int'(bus.plot_x) !== mq[0].x || int'(bus.plot_y) !== mq[0].y || int'(bus.plot_colour) !== mq[0].c) begin
            fails++;
            $display("FAIL bp_head: x=%0d y=%0d c=%0d, want %0d %0d %0d",
                     bus.plot_x, bus.plot_y, bus.plot_colour, mq[0].x, mq[0].y, mq[0].c);
        end
        snap = {bus.plot_x, bus.plot_y, bus.plot_colour};
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({bus.plot_x, bus.plot_y, bus.plot_colour} !== snap || bus.plot !== 1'b1) begin
                fails++;
                $display("FAIL bp_stable: head=%h plot=%b, want %h 1", {bus.plot_x, bus.plot_y, bus.plot_colour}, bus.plot, snap);
            end
        end
        bus.plot_ready = 1'b1;
        finish_and_drain(to);
        tests++;
        if (got_q.size() !== 4 || diff_pixels() !== 0 || pixel_count !== 17'd4 || to !== 1'b0) begin
            fails++;
            $display("FAIL bp_drain: got=%0d diffs=%0d cnt=%0d timeout=%b, want 4 0 4 0",
                     got_q.size(), diff_pixels(), pixel_count, to);
        end
    endtask

    task automatic test_clip();
        bit to;
        int d0;
        start_test();
        d0 = done_cnt;
        bus.plot_ready = 1'b1;
        tile_mode = 1'b0;
        colour = 3'b011;
        offset = {8'd240, 9'd0};
        wr_en = 1'b1;
        tick();
        offset = {8'd0, 9'd320};
        tick();
        wr_en = 1'b0;
        tests++;
        if (bus.plot !== 1'b0 || clipped !== 1'b1 || pixel_count !== 17'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL clip_flags: plot=%b clip=%b cnt=%0d ovf=%b, want 0 1 0 0", bus.plot, clipped, pixel_count, overflow);
        end
        finish_and_drain(to);
        tests++;
        if (to !== 1'b0 || done_cnt - d0 !== 1 || got_q.size() !== 0) begin
            fails++;
            $display("FAIL clip_done: timeout=%b pulses=%0d got=%0d, want 0 1 0", to, done_cnt - d0, got_q.size());
        end
    endtask

    task automatic test_random();
        bit to;
        start_test();
        for (int i = 0; i < 400; i++) begin
            bus.plot_ready = ($urandom_range(0, 3) != 0);
            wr_en = ($urandom_range(0, 2) != 0);
            tile_mode = 1'($urandom_range(0, 1));
            tile_col = 5'($urandom_range(0, 21));
            tile_row = 4'($urandom_range(0, 15));
            offset = 17'($urandom);
            colour = 3'($urandom_range(0, 7));
            tick();
        end
        wr_en = 1'b0;
        bus.plot_ready = 1'b1;
        finish_and_drain(to);
        tests++;
        if (diff_pixels() !== 0 || to !== 1'b0) begin
            fails++;
            $display("FAIL rand_stream: diffs=%0d got=%0d exp=%0d timeout=%b", diff_pixels(), got_q.size(), exp_q.size(), to);
        end
        tests++;
        if (pixel_count !== 17'(m_count) || overflow !== m_ovf || clipped !== m_clip) begin
            fails++;
            $display("FAIL rand_stats: cnt=%0d ovf=%b clip=%b, want %0d %b %b",
                     pixel_count, overflow, clipped, m_count, m_ovf, m_clip);
        end
    endtask

    task automatic test_transparency();
        bit to;
        int want;
        logic [2:0] cols [3];
        cols[0] = 3'b101;
        cols[1] = 3'b001;
        cols[2] = 3'b101;
        start_test();
        bus.plot_ready = 1'b1;
        tile_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offset = {8'(20 + i), 9'(100 + i)};
            colour = cols[i];
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        finish_and_drain(to);
`ifdef TRANSPARENCY_EN
        want = 1;
`else
        want = 3;
`endif
        tests++;
        if (pixel_count !== 17'(want) || got_q.size() !== want || diff_pixels() !== 0 || to !== 1'b0) begin
            fails++;
            $display("FAIL transparency: cnt=%0d got=%0d diffs=%0d, want %0d %0d 0", pixel_count, got_q.size(), diff_pixels(), want, want);
        end
`ifdef TRANSPARENCY_EN
        tests++;
        if (got_q.size() < 1 || got_q[0].c !== 1 || clipped !== 1'b0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL transparency_colour: got=%0d pixels clip=%b ovf=%b, want one colour-1 pixel, flags 0", got_q.size(), clipped, overflow);
        end
`endif
    endtask

    task automatic test_reset_mid_drain();
        int d0;
        start_test();
        bus.plot_ready = 1'b0;
        tile_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            offset = {8'(50 + i), 9'(60 + i)};
            colour = 3'(i);
            wr_en = 1'b1;
            tick();
        end
        wr_en = 1'b0;
        src_finished = 1'b1;
        tick();
        src_finished = 1'b0;
        tests++;
        if (bus.plot !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_pre: plot=%b busy=%b, want 1 1", bus.plot, busy);
        end
        d0 = done_cnt;
        reset_n = 1'b1;
        #1;
        tests++;
        if (bus.plot !== 1'b0 || busy !== 1'b0 || pixel_count !== 17'd0) begin
            fails++;
            $display("FAIL rst_mid_async: plot=%b busy=%b cnt=%0d, want 0 0 0", bus.plot, busy, pixel_count);
        end
        @(negedge clk);
        tests++;
        if (bus.plot !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_hold: plot=%b done=%b, want 0 0", bus.plot, done);
        end
        reset_n = 1'b0;
        model_reset();
        bus.plot_ready = 1'b1;
        repeat (6) tick();
        tests++;
        if (done_cnt !== d0 || bus.plot !== 1'b0 || busy !== 1'b0 || got_q.size() !== 0) begin
            fails++;
            $display("FAIL rst_mid_after: pulses=%0d plot=%b busy=%b got=%0d, want 0 0 0 0",
                     done_cnt - d0, bus.plot, busy, got_q.size());
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        done_cnt = 0;
        bus.plot_ready = 1'b0;
        test_reset();
        test_single();
        test_tile();
        test_backpressure();
        test_clip();
        test_random();
        test_transparency();
        test_reset_mid_drain();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end
endmodule
